// File: rtl/display_pkg.sv
// Shared display constants and the fetch-arbiter state type, also used by the 480p timing generator.
package display_pkg;

    typedef enum logic [0:0] {
        FS_ACTIVE = 1'b0,
        FS_BLANK  = 1'b1
    } fetch_state_e;

    // Horizontal blanking pixels per line at 640x480.
    localparam int HBLANK_PIX = 160;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          found
);

    logic [PW-1:0] pos_s;
    logic          hit_s;

    // Walk the N positions in priority order starting at ptr.
    always_comb begin
        gnt   = {N{1'b0}};
        idx   = {PW{1'b0}};
        found = 1'b0;
        pos_s = {PW{1'b0}};
        hit_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos_s      = PW'((int'(ptr) + k) % N);
            hit_s      = !found && req[pos_s];
            gnt[pos_s] = hit_s;
            idx        = hit_s ? pos_s : idx;
            found      = found | hit_s;
        end
    end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Shares one sprite/glyph ROM port among N_REQ requesters, granting reads only during blanking,
// with a per-blank grant budget, fixed-latency tagged read return and sticky overrun reporting.
module sprite_fetch_arbiter
    import display_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADDRW   = 10,
    parameter int DATAW   = 16,
    parameter int ROM_LAT = 2,
    parameter int MAX_GNT = HBLANK_PIX
) (
    input  logic                   clk_pix,
    input  logic                   rst_pix_n,
    input  logic                   de,
    input  logic                   frame,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*ADDRW-1:0] addr,
    output logic [N_REQ-1:0]       gnt,
    output logic                   rom_en,
    output logic [ADDRW-1:0]       rom_addr,
    input  logic [DATAW-1:0]       rom_data,
    output logic [N_REQ-1:0]       rvalid,
    output logic [DATAW-1:0]       rdata,
    output logic                   busy,
    output logic                   overrun
);

    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW   = $clog2(MAX_GNT + 1);
    localparam int LAST = ROM_LAT - 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_GNT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [PW-1:0] PTR_TOP = PW'(N_REQ - 1);

    fetch_state_e      state_r;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_eff_s;
    logic [PW-1:0]     ptr_r;
    logic [PW-1:0]     win_idx_s;
    logic [N_REQ-1:0]  arb_gnt_s;
    logic              arb_found_s;
    logic              gnt_en_s;
    logic              gnt_any_s;
    logic              de_rise_s;
    logic [ADDRW-1:0]  addr_a_s [N_REQ];

    logic              rom_en_r;
    logic [ADDRW-1:0]  rom_addr_r;
    logic              busy_r;
    logic              overrun_r;
    logic [ROM_LAT-1:0] tag_vld_r;
    logic [PW-1:0]     tag_idx_r [ROM_LAT];
    logic [N_REQ-1:0]  rvalid_r;
    logic [DATAW-1:0]  rdata_r;

    for (genvar g = 0; g < N_REQ; g++) begin : g_addr
        assign addr_a_s[g] = addr[g*ADDRW +: ADDRW];
    end

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
        .req   (req),
        .ptr   (ptr_r),
        .gnt   (arb_gnt_s),
        .idx   (win_idx_s),
        .found (arb_found_s)
    );

    // Grant qualification; the first blank cycle sees a fresh budget before cnt_r is cleared.
    always_comb begin
        cnt_eff_s = (state_r == FS_BLANK) ? cnt_r : {CW{1'b0}};
        gnt_en_s  = rst_pix_n && !de && (cnt_eff_s < CNT_MAX);
        gnt_any_s = gnt_en_s && arb_found_s;
        gnt       = gnt_en_s ? arb_gnt_s : {N_REQ{1'b0}};
        de_rise_s = (state_r == FS_BLANK) && de;
    end

    // Blank/active FSM, grant budget, RR pointer, ROM request and overrun flag.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            state_r    <= FS_ACTIVE;
            cnt_r      <= {CW{1'b0}};
            ptr_r      <= {PW{1'b0}};
            rom_en_r   <= 1'b0;
            rom_addr_r <= {ADDRW{1'b0}};
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            case (state_r)
                FS_ACTIVE: begin
                    if (!de) begin
                        state_r <= FS_BLANK;
                        cnt_r   <= gnt_any_s ? CNT_ONE : {CW{1'b0}};
                    end else begin
                        state_r <= FS_ACTIVE;
                        cnt_r   <= cnt_r;
                    end
                end
                FS_BLANK: begin
                    if (de) begin
                        state_r <= FS_ACTIVE;
                        cnt_r   <= cnt_r;
                    end else begin
                        state_r <= FS_BLANK;
                        cnt_r   <= gnt_any_s ? cnt_r + CNT_ONE : cnt_r;
                    end
                end
                default: begin
                    state_r <= FS_ACTIVE;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase

            // frame takes priority: a same-cycle grant was already arbitrated with the old pointer.
            if (frame) begin
                ptr_r <= {PW{1'b0}};
            end else if (gnt_any_s) begin
                ptr_r <= (win_idx_s == PTR_TOP) ? {PW{1'b0}} : win_idx_s + PW'(1'b1);
            end else begin
                ptr_r <= ptr_r;
            end

            rom_en_r <= gnt_any_s;
            if (gnt_any_s) begin
                rom_addr_r <= addr_a_s[win_idx_s];
            end else begin
                rom_addr_r <= rom_addr_r;
            end

            busy_r <= gnt_any_s | (|tag_vld_r);

            if (de_rise_s && (|req)) begin
                overrun_r <= 1'b1;
            end else if (frame) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    // Tag pipeline: remembers which requester owns each in-flight read and returns its data.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            tag_vld_r <= {ROM_LAT{1'b0}};
            for (int s = 0; s < ROM_LAT; s++) begin
                tag_idx_r[s] <= {PW{1'b0}};
            end
            rvalid_r <= {N_REQ{1'b0}};
            rdata_r  <= {DATAW{1'b0}};
        end else begin
            tag_vld_r[0] <= gnt_any_s;
            tag_idx_r[0] <= win_idx_s;
            for (int s = 1; s < ROM_LAT; s++) begin
                tag_vld_r[s] <= tag_vld_r[s-1];
                tag_idx_r[s] <= tag_idx_r[s-1];
            end
            if (tag_vld_r[LAST]) begin
                rvalid_r <= {{(N_REQ-1){1'b0}}, 1'b1} << tag_idx_r[LAST];
                rdata_r  <= rom_data;
            end else begin
                rvalid_r <= {N_REQ{1'b0}};
                rdata_r  <= rdata_r;
            end
        end
    end

    assign rom_en   = rom_en_r;
    assign rom_addr = rom_addr_r;
    assign rvalid   = rvalid_r;
    assign rdata    = rdata_r;
    assign busy     = busy_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Randomized scoreboard bench for sprite_fetch_arbiter against a behavioural model of the grant rules.
module tb_sprite_fetch_arbiter;

    localparam int N    = 4;
    localparam int AW   = 10;
    localparam int DW   = 16;
    localparam int LAT  = 2;
    localparam int MAXG = 8;

    logic              clk_pix = 1'b1;
    logic              rst_pix_n;
    logic              de;
    logic              frame;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   addr;
    logic [N-1:0]      gnt;
    logic              rom_en;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data = '0;
    logic [N-1:0]      rvalid;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic              overrun;

    always #5 clk_pix = ~clk_pix;

    sprite_fetch_arbiter #(
        .N_REQ(N), .ADDRW(AW), .DATAW(DW), .ROM_LAT(LAT), .MAX_GNT(MAXG)
    ) dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .de(de), .frame(frame),
        .req(req), .addr(addr), .gnt(gnt), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .rvalid(rvalid), .rdata(rdata), .busy(busy), .overrun(overrun)
    );

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return (DW'(a) * 16'd40503) ^ 16'hA5C3;
    endfunction

    // Synchronous ROM: data one cycle after rom_en, i.e. gnt -> rvalid in 1+LAT cycles.
    always @(posedge clk_pix) begin
        if (rom_en) rom_data <= rom_fn(rom_addr);
    end

    typedef struct {
        int          idx;
        logic [DW-1:0] data;
        int          due;
    } rd_t;

    rd_t sb_q[$];
    rd_t keep_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;

    // Behavioural model state
    int          m_ptr, m_cnt;
    bit          m_blank, m_ovr, m_valid;
    bit [2:0]    m_hist;
    bit          m_rom_en;
    logic [AW-1:0] m_rom_addr;
    int          obs_cnt;
    logic [N-1:0] obs_log[$];
    bit          mon_valid;
    logic [DW-1:0] mon_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk_pix);
        cyc++;
    end

    // Reference model: grants per round-robin rules, pushes expected reads to the scoreboard.
    initial forever begin
        int w, j;
        logic [N-1:0] eg;
        logic [AW-1:0] a_w;
        @(negedge clk_pix);
        if (m_valid) begin
            chk("rom_en", 32'(rom_en), 32'(m_rom_en));
            chk("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
            chk("busy", 32'(busy), 32'(|m_hist));
            chk("overrun", 32'(overrun), 32'(m_ovr));
        end
        if (!de && !m_blank) m_cnt = 0;
        w = -1;
        if (rst_pix_n === 1'b1 && !de && m_cnt < MAXG) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (w < 0 && req[2'(j)]) w = j;
            end
        end
        eg = '0;
        if (w >= 0) eg[2'(w)] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        if (gnt != '0) begin
            obs_cnt++;
            obs_log.push_back(gnt);
        end
        if (!rst_pix_n) begin
            m_ptr = 0; m_cnt = 0; m_blank = 0; m_ovr = 0; m_hist = '0;
            m_rom_en = 0; m_rom_addr = '0; m_valid = 1;
            keep_q.delete();
            foreach (sb_q[i]) if (sb_q[i].due <= cyc) keep_q.push_back(sb_q[i]);
            sb_q = keep_q;
        end else begin
            m_hist = {m_hist[1:0], w >= 0};
            m_rom_en = (w >= 0);
            if (w >= 0) begin
                a_w = addr[w*AW +: AW];
                m_rom_addr = a_w;
                sb_q.push_back('{idx: w, data: rom_fn(a_w), due: cyc + 1 + LAT});
                m_ptr = (w + 1) % N;
                m_cnt++;
            end
            if (de && m_blank && req != '0) m_ovr = 1;
            else if (frame) m_ovr = 0;
            if (frame) m_ptr = 0;
            m_blank = !de;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT returns read data.
    initial forever begin
        rd_t e;
        @(negedge clk_pix);
        if (mon_valid) begin
            if (rvalid != '0) begin
                if (sb_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'(rvalid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rvalid_idx", 32'(rvalid), 32'd1 << e.idx);
                    chk("rdata", 32'(rdata), 32'(e.data));
                    chk("rvalid_time", cyc, e.due);
                    mon_last = e.data;
                end
            end else begin
                chk("rdata_hold", 32'(rdata), 32'(mon_last));
                if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                    e = sb_q.pop_front();
                    chk("rvalid_missing", 32'(rvalid), 32'd1 << e.idx);
                end
            end
        end
        if (!rst_pix_n) begin
            mon_valid = 1;
            mon_last  = '0;
        end
    end

    task automatic tick(input logic r, input logic d, input logic f, input logic [N-1:0] q);
        rst_pix_n = r; de = d; frame = f; req = q;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'($urandom);
        @(posedge clk_pix);
        #1;
    endtask

    initial begin
        logic [N-1:0] rr_exp [8];
        logic d, f, r;
        int run;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        // Reset with everything requesting
        repeat (3) tick(1'b0, 1'b0, 1'b0, 4'b1111);
        chk("reset_rom_en", 32'(rom_en), 32'd0);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Round-robin fairness
        obs_log.delete();
        repeat (8) tick(1'b1, 1'b0, 1'b0, 4'b1111);
        chk("rr_count", obs_log.size(), 8);
        foreach (rr_exp[i]) if (i < obs_log.size()) chk("rr_order", 32'(obs_log[i]), 32'(rr_exp[i]));
        tick(1'b1, 1'b1, 1'b0, 4'b1111);
        chk("rr_overrun", 32'(overrun), 32'd1);
        repeat (4) tick(1'b1, 1'b1, 1'b0, 4'b0000);
        tick(1'b1, 1'b1, 1'b1, 4'b0000);
        chk("frame_clears_ovr", 32'(overrun), 32'd0);

        // Gating in active video, last-blank-cycle grant drains during de=1
        obs_cnt = 0;
        repeat (3) tick(1'b1, 1'b1, 1'b0, 4'b0100);
        chk("gate_no_gnt", obs_cnt, 0);
        tick(1'b1, 1'b0, 1'b0, 4'b0100);
        repeat (5) tick(1'b1, 1'b1, 1'b0, 4'b0100);
        chk("gate_overrun", 32'(overrun), 32'd1);
        tick(1'b1, 1'b1, 1'b1, 4'b0000);
        chk("gate_ovr_clear", 32'(overrun), 32'd0);

        // Grant budget
        obs_cnt = 0;
        repeat (12) tick(1'b1, 1'b0, 1'b0, 4'b0001);
        chk("budget_grants", obs_cnt, MAXG);
        tick(1'b1, 1'b1, 1'b0, 4'b0001);
        chk("budget_overrun", 32'(overrun), 32'd1);
        repeat (3) tick(1'b1, 1'b1, 1'b0, 4'b0000);
        obs_cnt = 0;
        repeat (3) tick(1'b1, 1'b0, 1'b0, 4'b0001);
        chk("budget_resume", obs_cnt, 3);

        // frame resets the pointer
        tick(1'b1, 1'b1, 1'b1, 4'b0000);
        tick(1'b1, 1'b0, 1'b0, 4'b0010);
        tick(1'b1, 1'b1, 1'b0, 4'b0000);
        tick(1'b1, 1'b1, 1'b1, 4'b0000);
        obs_log.delete();
        tick(1'b1, 1'b0, 1'b0, 4'b1111);
        chk("frame_ptr_first", 32'(obs_log.size() > 0 ? obs_log[0] : 4'b0000), 32'd1);
        tick(1'b1, 1'b1, 1'b1, 4'b1111);
        chk("ovr_set_wins", 32'(overrun), 32'd1);
        tick(1'b1, 1'b1, 1'b1, 4'b0000);

        // Reset while a read is in flight
        tick(1'b1, 1'b0, 1'b0, 4'b0001);
        tick(1'b0, 1'b0, 1'b0, 4'b0001);
        chk("midreset_busy", 32'(busy), 32'd0);
        repeat (6) tick(1'b1, 1'b1, 1'b0, 4'b0000);

        // Random traffic
        d = 1'b1; run = 0;
        for (int i = 0; i < 600; i++) begin
            if (run == 0) begin
                d = ~d;
                run = d ? $urandom_range(30, 10) : $urandom_range(20, 2);
            end
            run--;
            f = ($urandom_range(39, 0) == 0);
            r = ($urandom_range(199, 0) != 0);
            tick(r, d, f, 4'($urandom));
        end

        repeat (6) tick(1'b1, 1'b1, 1'b0, 4'b0000);
        chk("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
